io_arb_2to1: RTL and testbench

IO_ARB_2TO1 -- requirements
Module: io_arb_2to1

---
 rtl/io_arb_2to1_if.sv | 26 ++
 rtl/io_arb_2to1.sv | 201 ++++++++++++++++++++
 tb/tb_io_arb_2to1.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_arb_2to1_if.sv
// Message + four-phase handshake bundle used on every io_arb_2to1 port.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

interface io_arb_2to1_if #(
  parameter int unsigned ASZ = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ = `NS_DATA_SIZE,
  parameter int unsigned RSZ = `NS_REDUN_SIZE
);
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output src, output dst, output dat, output red, output req, input ack);
  modport slave  (input src, input dst, input dat, input red, input req, output ack);
endinterface

// File: rtl/io_arb_2to1.sv
// Two-requester round-robin arbiter merging four-phase message channels onto one output.
// Optional redundancy checking of granted messages is enabled by defining NS_ARB_REDUN_CHK_EN.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

`ifdef NS_ARB_REDUN_CHK_EN
// XOR-folds {src,dst,dat} into an RSZ-bit redundancy word.
module calc_redun #(
  parameter int unsigned ASZ = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ = `NS_DATA_SIZE,
  parameter int unsigned RSZ = `NS_REDUN_SIZE
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red_c
);
  localparam int unsigned MW = 2 * ASZ + DSZ;
  logic [MW-1:0] msg_c;

  assign msg_c = {src, dst, dat};

  always_comb begin
    red_c = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      red_c[i % RSZ] = red_c[i % RSZ] ^ msg_c[i];
    end
  end
endmodule
`endif

module io_arb_2to1 #(
  parameter int unsigned ASZ = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ = `NS_DATA_SIZE,
  parameter int unsigned RSZ = `NS_REDUN_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  io_arb_2to1_if.slave      i0,
  io_arb_2to1_if.slave      i1,
  io_arb_2to1_if.master     o0,
  output logic [3:0]        dbg_leds
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LATCH = 3'd1;
  localparam logic [2:0] IREL  = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] OREL  = 3'd4;

  logic [2:0]     state, state_nxt;
  logic           gnt, gnt_nxt;
  logic           last, last_nxt;
  logic           ack0_q, ack0_nxt;
  logic           ack1_q, ack1_nxt;
  logic           oreq_q, oreq_nxt;
  logic           oack_low_seen, oack_low_seen_nxt;
  logic           busy_q;
  logic [ASZ-1:0] src_q, src_nxt;
  logic [ASZ-1:0] dst_q, dst_nxt;
  logic [DSZ-1:0] dat_q, dat_nxt;
  logic [RSZ-1:0] red_q, red_nxt;
  logic           elig0_c, elig1_c, gnt_req_c;
  logic           err0_q, err1_q;

  assign i0.ack   = ack0_q;
  assign i1.ack   = ack1_q;
  assign o0.req   = oreq_q;
  assign o0.src   = src_q;
  assign o0.dst   = dst_q;
  assign o0.dat   = dat_q;
  assign o0.red   = red_q;
  assign dbg_leds = {busy_q, err1_q, err0_q, last};

  assign elig0_c   = i0.req && !ack0_q;
  assign elig1_c   = i1.req && !ack1_q;
  assign gnt_req_c = gnt ? i1.req : i0.req;

  // State and registered-output update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      gnt           <= 1'b0;
      last          <= 1'b1;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      oreq_q        <= 1'b0;
      oack_low_seen <= 1'b0;
      busy_q        <= 1'b0;
      src_q         <= '0;
      dst_q         <= '0;
      dat_q         <= '0;
      red_q         <= '0;
    end else begin
      state         <= state_nxt;
      gnt           <= gnt_nxt;
      last          <= last_nxt;
      ack0_q        <= ack0_nxt;
      ack1_q        <= ack1_nxt;
      oreq_q        <= oreq_nxt;
      oack_low_seen <= oack_low_seen_nxt;
      busy_q        <= (state_nxt != IDLE);
      src_q         <= src_nxt;
      dst_q         <= dst_nxt;
      dat_q         <= dat_nxt;
      red_q         <= red_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt         = state;
    gnt_nxt           = gnt;
    last_nxt          = last;
    ack0_nxt          = ack0_q;
    ack1_nxt          = ack1_q;
    oreq_nxt          = oreq_q;
    oack_low_seen_nxt = oack_low_seen;
    src_nxt           = src_q;
    dst_nxt           = dst_q;
    dat_nxt           = dat_q;
    red_nxt           = red_q;
    case (state)
      IDLE: begin
        if (elig0_c && elig1_c) begin
          gnt_nxt   = ~last;
          state_nxt = LATCH;
        end else if (elig0_c) begin
          gnt_nxt   = 1'b0;
          state_nxt = LATCH;
        end else if (elig1_c) begin
          gnt_nxt   = 1'b1;
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        src_nxt   = gnt ? i1.src : i0.src;
        dst_nxt   = gnt ? i1.dst : i0.dst;
        dat_nxt   = gnt ? i1.dat : i0.dat;
        red_nxt   = gnt ? i1.red : i0.red;
        last_nxt  = gnt;
        ack0_nxt  = !gnt;
        ack1_nxt  = gnt;
        state_nxt = IREL;
      end
      IREL: begin
        if (!gnt_req_c) begin
          ack0_nxt          = 1'b0;
          ack1_nxt          = 1'b0;
          oreq_nxt          = 1'b1;
          oack_low_seen_nxt = 1'b0;
          state_nxt         = SEND;
        end
      end
      SEND: begin
        // An ack still high from the previous transfer is ignored until it is seen low.
        if (!o0.ack) begin
          oack_low_seen_nxt = 1'b1;
        end else if (oack_low_seen) begin
          oreq_nxt  = 1'b0;
          state_nxt = OREL;
        end
      end
      OREL: begin
        if (!o0.ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef NS_ARB_REDUN_CHK_EN
  logic [RSZ-1:0] calc0_c, calc1_c;

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc0 (
    .src(i0.src), .dst(i0.dst), .dat(i0.dat), .red_c(calc0_c)
  );
  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc1 (
    .src(i1.src), .dst(i1.dst), .dat(i1.dat), .red_c(calc1_c)
  );

  // Sticky error flags, checked only for the granted requester while latching
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else if (state == LATCH) begin
      if (!gnt && (calc0_c != i0.red)) err0_q <= 1'b1;
      if (gnt && (calc1_c != i1.red))  err1_q <= 1'b1;
    end
  end
`else
  assign err0_q = 1'b0;
  assign err1_q = 1'b0;
`endif
endmodule

// File: tb/tb_io_arb_2to1.sv
// Directed bench for io_arb_2to1: handshake timing, round-robin, stalls, reset, redundancy flags.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module tb_io_arb_2to1;
  localparam int unsigned ASZ = `NS_ADDRESS_SIZE;
  localparam int unsigned DSZ = `NS_DATA_SIZE;
  localparam int unsigned RSZ = `NS_REDUN_SIZE;
`ifdef NS_ARB_REDUN_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dbg_leds;
  int         total = 0;
  int         bad = 0;

  io_arb_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) i0 ();
  io_arb_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) i1 ();
  io_arb_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) o0 ();

  io_arb_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_dut (
    .clk(clk), .reset(reset), .i0(i0), .i1(i1), .o0(o0), .dbg_leds(dbg_leds)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [RSZ-1:0] ref_red(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                             input logic [DSZ-1:0] x);
    logic [2*ASZ+DSZ-1:0] m;
    logic [RSZ-1:0]       r;
    m = {s, d, x};
    r = '0;
    for (int unsigned i = 0; i < 2 * ASZ + DSZ; i++) r[i % RSZ] = r[i % RSZ] ^ m[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Plays both requesters (release on ack) and the output sink (ack on the 2nd cycle of o0_req).
  task automatic run_xfer(input bit rearm, output int g, output logic [DSZ-1:0] dat,
                          output logic [RSZ-1:0] red);
    bit done = 1'b0;
    int seen = 0;
    g = -1;
    dat = '0;
    red = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      step(1);
      if (i0.ack && i0.req) begin g = 0; i0.req = 1'b0; end
      else if (i1.ack && i1.req) begin g = 1; i1.req = 1'b0; end
      if (o0.req) begin
        seen++;
        dat = o0.dat;
        red = o0.red;
        if (seen >= 2) o0.ack = 1'b1;
      end else if (o0.ack) begin
        o0.ack = 1'b0;
        done = 1'b1;
      end
    end
    check("xfer_done", 32'(done), 32'd1);
    if (rearm && g == 0) i0.req = 1'b1;
    if (rearm && g == 1) i1.req = 1'b1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    i0.req = 1'b0;
    i1.req = 1'b0;
    o0.ack = 1'b0;
    step(2);
    @(negedge clk);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    int             g;
    logic [DSZ-1:0] d;
    logic [RSZ-1:0] r;
    logic [DSZ-1:0] held;
    bit             ok_req, ok_dat, ok_ack, spurious;
    bit             got;

    reset  = 1'b0;
    i0.req = 1'b0; i0.src = 8'(1); i0.dst = 8'(2); i0.dat = DSZ'(5);
    i1.req = 1'b0; i1.src = 8'(3); i1.dst = 8'(4); i1.dat = DSZ'('hB1);
    i0.red = ref_red(i0.src, i0.dst, i0.dat);
    i1.red = ref_red(i1.src, i1.dst, i1.dat);
    o0.ack = 1'b0;
    #12;
    check("rst_o0_req", 32'(o0.req), 32'd0);
    check("rst_acks", 32'({i0.ack, i1.ack}), 32'd0);
    check("rst_o0_dat", 32'(o0.dat), 32'd0);
    check("rst_dbg", 32'(dbg_leds), 32'b0001);
    @(negedge clk);
    reset = 1'b1;
    step(1);

    // Single i0 transfer with the sink echoing 2 clocks after o0_req
    i0.req = 1'b1;
    step(1);
    check("t1_ack_e1", 32'(i0.ack), 32'd0);
    check("t1_busy", 32'(dbg_leds[3]), 32'd1);
    step(1);
    check("t1_ack_e2", 32'(i0.ack), 32'd1);
    check("t1_dat", 32'(o0.dat), 32'd5);
    check("t1_last", 32'(dbg_leds[0]), 32'd0);
    check("t1_oreq_e2", 32'(o0.req), 32'd0);
    i0.req = 1'b0;
    step(1);
    check("t1_oreq_e3", 32'(o0.req), 32'd1);
    check("t1_ack_e3", 32'(i0.ack), 32'd0);
    step(2);
    o0.ack = 1'b1;
    step(1);
    check("t1_oreq_drop", 32'(o0.req), 32'd0);
    o0.ack = 1'b0;
    step(1);
    check("t1_idle_dbg", 32'(dbg_leds), 32'b0000);
    check("t1_i1_ack", 32'(i1.ack), 32'd0);

    // Simultaneous requests from reset alternate 0,1,0,1
    do_reset();
    i0.dat = DSZ'('hA0);
    i0.red = ref_red(i0.src, i0.dst, i0.dat);
    i0.req = 1'b1;
    i1.req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_xfer(k < 3, g, d, r);
      check("rr_grant", 32'(g), 32'(k % 2));
      check("rr_dbg0", 32'(dbg_leds[0]), 32'(k % 2));
      check("rr_dat", 32'(d), (k % 2) ? 32'h00B1 : 32'h00A0);
    end

    // Output stall for 20 clocks with i1 pending, then reset mid-SEND
    do_reset();
    i0.req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin step(1); got = i0.ack; end
    check("st_i0_ack", 32'(got), 32'd1);
    i0.req = 1'b0;
    i1.req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin step(1); got = o0.req; end
    check("st_oreq_up", 32'(got), 32'd1);
    held = o0.dat;
    check("st_held_dat", 32'(held), 32'h00A0);
    ok_req = 1'b1; ok_dat = 1'b1; ok_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      ok_req &= o0.req;
      ok_dat &= (o0.dat === held);
      ok_ack &= !i1.ack;
    end
    check("st_oreq_held", 32'(ok_req), 32'd1);
    check("st_dat_stable", 32'(ok_dat), 32'd1);
    check("st_i1_not_acked", 32'(ok_ack), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_oreq", 32'(o0.req), 32'd0);
    check("ar_acks", 32'({i0.ack, i1.ack}), 32'd0);
    check("ar_dat", 32'(o0.dat), 32'd0);
    check("ar_dbg", 32'(dbg_leds), 32'b0001);

    // After release both pending: i0 first, then i1 with a corrupted redundancy word
    i0.req = 1'b1;
    i1.red = ref_red(i1.src, i1.dst, i1.dat) ^ RSZ'(1);
    @(negedge clk);
    reset = 1'b1;
    run_xfer(1'b0, g, d, r);
    check("ar_regrant_i0", 32'(g), 32'd0);
    check("ar_i0_noerr", 32'(dbg_leds[1]), 32'd0);
    run_xfer(1'b0, g, d, r);
    check("red_grant_i1", 32'(g), 32'd1);
    check("red_fwd", 32'(r), 32'(i1.red));
    check("red_err1", 32'(dbg_leds[2]), 32'(ERR_EXP));

    // i1 pulses while i0 is busy and again between clock edges in IDLE: never granted
    i0.req = 1'b1;
    step(1);
    i1.req = 1'b1;
    step(1);
    i1.req = 1'b0;
    run_xfer(1'b0, g, d, r);
    check("gap_grant_i0", 32'(g), 32'd0);
    check("red_sticky", 32'(dbg_leds[2]), 32'(ERR_EXP));
    step(2);
    i1.req = 1'b1;
    #2;
    i1.req = 1'b0;
    spurious = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      spurious |= (i1.ack || o0.req || i0.ack);
    end
    check("gap_no_spurious", 32'(spurious), 32'd0);
    check("gap_idle_dbg", 32'(dbg_leds), {28'd0, 1'b0, ERR_EXP, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
